// File: rtl/sync_fifo_pkg.sv
// Shared defaults and sizing helpers for the single-clock FIFO.
package sync_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 8;

    // Index bits plus one wrap bit, so full and empty stay distinguishable.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bus of the FIFO; master drives requests, slave is the FIFO.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  w_en;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;

    modport master (
        output w_en,
        output r_en,
        output data_in,
        input  data_out,
        input  full,
        input  empty
    );

    modport slave (
        input  w_en,
        input  r_en,
        input  data_in,
        output data_out,
        output full,
        output empty
    );

endinterface

// File: rtl/sync_fifo_ptr.sv
// Wrap-bit pointer register with increment enable and synchronous reset.
module sync_fifo_ptr #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    // Free-running modulo 2**WIDTH; the top bit flips once per lap of the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: register-array storage, wrap-bit pointers, registered read data.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    sync_fifo_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = ptr_width(DEPTH);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  full_w;
    logic                  empty_w;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Flags decode only registered pointers, never the request inputs.
    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);

    assign wr_fire = bus.w_en && !full_w;
    assign rd_fire = bus.r_en && !empty_w;

    sync_fifo_ptr #(.WIDTH(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_fire),
        .ptr (wr_ptr)
    );

    sync_fifo_ptr #(.WIDTH(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_fire),
        .ptr (rd_ptr)
    );

    // Storage is deliberately not cleared; reset only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= bus.data_in;
        end
    end

    // Same-cycle write into an empty FIFO is not bypassed here.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_fire) begin
            rd_data_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    assign bus.data_out = rd_data_q;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: queue of written words popped on each accepted read.
module tb_sync_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] model_dout = '0;

    // One clock of stimulus; the scoreboard is updated from pre-edge occupancy.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        int unsigned occ;
        @(negedge clk);
        bus.w_en    = w;
        bus.r_en    = r;
        bus.data_in = d;
        occ = sb.size();
        if (r && occ != 0) model_dout = sb.pop_front();
        if (w && occ != DEPTH) sb.push_back(d);
        @(posedge clk);
        #1;
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
    endtask

    task automatic pulse_reset(input logic w, input logic r);
        @(negedge clk);
        rst         = 1'b1;
        bus.w_en    = w;
        bus.r_en    = r;
        bus.data_in = 8'hEE;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        sb.delete();
        model_dout = '0;
    endtask

    task automatic test_reset();
        pulse_reset(1'b1, 1'b1);
        n_checks++;
        if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        n_checks++;
        if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", bus.full); end
        n_checks++;
        if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", bus.data_out); end
        step(1'b0, 1'b0, '0);
        n_checks++;
        if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_no_write got empty=%b want 1", bus.empty); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 1'b0, DW'(i));
            n_checks++;
            if (bus.full !== (i >= 8)) begin
                n_fail++; $display("FAIL ovf_full_w%0d got %b want %b", i, bus.full, (i >= 8));
            end
        end
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, '0);
            n_checks++;
            if (bus.data_out !== model_dout || model_dout !== DW'(i)) begin
                n_fail++; $display("FAIL ovf_read%0d got %h want %h", i, bus.data_out, DW'(i));
            end
        end
        n_checks++;
        if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty_after got %b want 1", bus.empty); end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, '0);
            n_checks++;
            if (bus.data_out !== 8'h08 || bus.empty !== 1'b1) begin
                n_fail++; $display("FAIL udf_hold%0d got dout=%h empty=%b want 08/1", i, bus.data_out, bus.empty);
            end
        end
        step(1'b1, 1'b0, 8'hA5);
        n_checks++;
        if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL udf_write_empty got %b want 0", bus.empty); end
        step(1'b0, 1'b1, '0);
        n_checks++;
        if (bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL udf_read got %h want a5", bus.data_out); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'(8'h20 + i));
        for (int i = 0; i < 6; i++) begin
            exp = sb[0];
            step(1'b0, 1'b1, '0);
            n_checks++;
            if (bus.data_out !== exp) begin n_fail++; $display("FAIL wrap_pre%0d got %h want %h", i, bus.data_out, exp); end
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(8'h10 + i));
        n_checks++;
        if (bus.full !== 1'b1) begin n_fail++; $display("FAIL wrap_full got %b want 1", bus.full); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, '0);
            n_checks++;
            if (bus.data_out !== DW'(8'h10 + i)) begin
                n_fail++; $display("FAIL wrap_read%0d got %h want %h", i, bus.data_out, DW'(8'h10 + i));
            end
        end
        n_checks++;
        if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] exp;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(8'h30 + i));
        for (int i = 0; i < 10; i++) begin
            exp = (i < 4) ? DW'(8'h30 + i) : DW'(8'h40 + i - 4);
            step(1'b1, 1'b1, DW'(8'h40 + i));
            n_checks++;
            if (bus.data_out !== exp || bus.full !== 1'b0 || bus.empty !== 1'b0) begin
                n_fail++; $display("FAIL simul%0d got dout=%h full=%b empty=%b want %h/0/0",
                                   i, bus.data_out, bus.full, bus.empty, exp);
            end
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(8'h50 + i));
        n_checks++;
        if (bus.full !== 1'b1) begin n_fail++; $display("FAIL simul_fill got full=%b want 1", bus.full); end
        step(1'b1, 1'b1, 8'h99);
        n_checks++;
        if (bus.full !== 1'b0 || bus.data_out !== 8'h46) begin
            n_fail++; $display("FAIL simul_full got full=%b dout=%h want 0/46", bus.full, bus.data_out);
        end
        for (int i = 0; i < 7; i++) begin
            exp = sb[0];
            step(1'b0, 1'b1, '0);
            n_checks++;
            if (bus.data_out !== exp || exp === 8'h99) begin
                n_fail++; $display("FAIL simul_drain%0d got %h want %h", i, bus.data_out, exp);
            end
        end
        n_checks++;
        if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL simul_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h60 + i));
        pulse_reset(1'b0, 1'b0);
        n_checks++;
        if (bus.empty !== 1'b1 || bus.data_out !== 8'h00) begin
            n_fail++; $display("FAIL midrst got empty=%b dout=%h want 1/00", bus.empty, bus.data_out);
        end
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, '0);
        n_checks++;
        if (bus.data_out !== 8'h77 || bus.empty !== 1'b1) begin
            n_fail++; $display("FAIL midrst_read got dout=%h empty=%b want 77/1", bus.data_out, bus.empty);
        end
    endtask

    task automatic test_random();
        logic w, r;
        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            step(w, r, DW'($urandom));
            n_checks++;
            if (bus.data_out !== model_dout || bus.empty !== (sb.size() == 0) ||
                bus.full !== (sb.size() == DEPTH)) begin
                n_fail++; $display("FAIL rand%0d got dout=%h e=%b f=%b want %h e=%b f=%b", i,
                                   bus.data_out, bus.empty, bus.full, model_dout,
                                   (sb.size() == 0), (sb.size() == DEPTH));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
        bus.data_in = '0;
        test_reset();
        test_overflow();
        test_underflow();
        test_wrap();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
